// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with 16x oversampling and mid-bit sampling.
//
// The rxd line is synchronised, a falling edge arms the receiver, the start bit
// is re-checked at its middle (glitch rejection), and each data/stop bit is
// sampled 16 oversample ticks after the previous sample point.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> an even-parity bit between D7 and stop; PARITY state exists.
//   undefined -> plain 8N1; parity_err is tied to 0.
//
// Parameters:
//   DIV        system clocks per oversample tick (2..65535)
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rxd        serial input, idle high, asynchronous to clk
//   word       last good byte (bit 0 received first), held until next good byte
//   valid      one-cycle pulse, word updated in the same cycle
//   frame_err  one-cycle pulse when the stop bit samples low
//   parity_err one-cycle pulse on parity mismatch (0 without the macro)
//   busy       high in every state except IDLE
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DIV = 651
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] word,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t      state_reg, state_next;
    logic        rx_meta_reg, rxs_reg, rxs_d_reg;
    logic [15:0] tick_cnt_reg, tick_cnt_next;
    logic [3:0]  sample_reg, sample_next;
    logic [2:0]  bit_reg, bit_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  word_reg, word_next;
    logic        valid_reg, valid_next;
    logic        frame_reg, frame_next;
    logic        tick;

`ifdef UART_RX_PARITY_EN
    logic        par_reg, par_next;
    logic        perr_reg, perr_next;
`endif

    // Oversample tick; the counter only runs outside IDLE.
    assign tick = (tick_cnt_reg == DIV_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Synchroniser resets high so the idle line never looks like an edge.
            rx_meta_reg  <= 1'b1;
            rxs_reg      <= 1'b1;
            rxs_d_reg    <= 1'b1;
            state_reg    <= S_IDLE;
            tick_cnt_reg <= '0;
            sample_reg   <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            word_reg     <= '0;
            valid_reg    <= 1'b0;
            frame_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_reg      <= 1'b0;
            perr_reg     <= 1'b0;
`endif
        end else begin
            rx_meta_reg  <= rxd;
            rxs_reg      <= rx_meta_reg;
            rxs_d_reg    <= rxs_reg;
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            sample_reg   <= sample_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            word_reg     <= word_next;
            valid_reg    <= valid_next;
            frame_reg    <= frame_next;
`ifdef UART_RX_PARITY_EN
            par_reg      <= par_next;
            perr_reg     <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        sample_next   = sample_reg;
        bit_next      = bit_reg;
        shift_next    = shift_reg;
        word_next     = word_reg;
        valid_next    = 1'b0;
        frame_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next      = par_reg;
        perr_next     = 1'b0;
`endif
        if (state_reg == S_IDLE) begin
            // Counters parked at 0, so START always begins from a clean count.
            tick_cnt_next = '0;
            sample_next   = '0;
            bit_next      = '0;
            // Only a real high->low transition arms; a line held low does not.
            if (rxs_d_reg && !rxs_reg) begin
                state_next = S_START;
            end
        end else begin
            tick_cnt_next = tick ? 16'd0 : tick_cnt_reg + 16'd1;
            if (tick) begin
                sample_next = sample_reg + 4'd1;
                case (state_reg)
                    S_START: begin
                        if (sample_reg == 4'd7) begin
                            if (rxs_reg) begin
                                state_next = S_IDLE;     // glitch, not a start bit
                            end else begin
                                state_next  = S_DATA;
                                sample_next = '0;        // next sample is one bit later
                            end
                        end
                    end
                    S_DATA: begin
                        if (sample_reg == 4'd15) begin
                            // Shift in from the MSB so the first bit ends up in bit 0.
                            shift_next = {rxs_reg, shift_reg[7:1]};
                            bit_next   = bit_reg + 3'd1;
                            if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_next = S_PARITY;
`else
                                state_next = S_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (sample_reg == 4'd15) begin
                            par_next   = rxs_reg;
                            state_next = S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        if (sample_reg == 4'd15) begin
                            state_next = S_IDLE;
                            if (!rxs_reg) begin
                                frame_next = 1'b1;       // framing error wins over parity
`ifdef UART_RX_PARITY_EN
                            end else if (^{shift_reg, par_reg}) begin
                                perr_next = 1'b1;
`endif
                            end else begin
                                word_next  = shift_reg;
                                valid_next = 1'b1;
                            end
                        end
                    end
                    default: state_next = S_IDLE;
                endcase
            end
        end
    end

    assign word      = word_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_reg;
    assign busy      = (state_reg != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_reg;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- scoreboard bench for uart_rx with DIV=4 (one bit = 64 clocks).
// Stimulus pushes the expected outcome (kind + word) into a queue; a monitor
// pops and compares whenever the DUT pulses valid, frame_err or parity_err.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DIV = 4;
    localparam int BIT = 16 * DIV;

    localparam logic [2:0] K_VALID  = 3'b001;
    localparam logic [2:0] K_FRAME  = 3'b010;
    localparam logic [2:0] K_PARITY = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] word;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] word;
    logic       valid, frame_err, parity_err, busy;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         pulses = 0;
    int         cyc = 0;
    int         edge_cyc = 0;
    int         valid_cyc = 0;
    logic [7:0] last_good = 8'h00;
`ifdef UART_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    uart_rx #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .word       (word),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one line per received outcome.
    always @(negedge clk) begin
        if (!rst && (valid || frame_err || parity_err)) begin
            exp_t e;
            logic [2:0] got;
            got = {parity_err, frame_err, valid};
            pulses++;
            if (valid) valid_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got kind=%03b word=%02h, required no pulse", got, word);
            end else begin
                e = exp_q.pop_front();
                if (got != e.kind || word != e.word) begin
                    errors++;
                    $display("FAIL rx_outcome: got kind=%03b word=%02h, required kind=%03b word=%02h",
                             got, word, e.kind, e.word);
                end else begin
                    $display("rx: kind=%03b word=%02h ok", got, word);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end else begin
            $display("check %s: %0h ok", name, got);
        end
    endtask

    task automatic expect_ev(input logic [2:0] kind, input logic [7:0] b);
        exp_t e;
        e.kind = kind;
        if (kind == K_VALID) last_good = b;
        e.word = last_good;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at a negedge right after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        edge_cyc = cyc;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^b) ^ par_flip;
        repeat (BIT) @(negedge clk);
`endif
        rxd = stop_bit;
        repeat (BIT) @(negedge clk);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_word", {24'd0, word}, 32'h00);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (500) @(negedge clk);
        check("idle_no_pulses", pulses, 0);

        // Single byte with latency check
        expect_ev(K_VALID, 8'hA5);
        send_frame(8'hA5, 1'b1);
        check("a5_latency_in_window",
              {31'd0, (valid_cyc - edge_cyc >= 600) && (valid_cyc - edge_cyc <= 620)}, 32'd1);
        repeat (20) @(negedge clk);

        // Back-to-back, no idle between frames
        expect_ev(K_VALID, 8'h00);
        expect_ev(K_VALID, 8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (40) @(negedge clk);

        // Glitch shorter than half a bit
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        repeat (10) @(negedge clk);
        rxd = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        expect_ev(K_VALID, 8'h3C);
        send_frame(8'h3C, 1'b1);
        repeat (40) @(negedge clk);

        // Framing error followed by a long break
        expect_ev(K_FRAME, 8'h55);
        send_frame(8'h55, 1'b0);
        repeat (2000) @(negedge clk);
        check("break_word_held", {24'd0, word}, 32'h3C);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        expect_ev(K_VALID, 8'h96);
        send_frame(8'h96, 1'b1);
        repeat (40) @(negedge clk);

        // Asynchronous reset during D3, held until the frame ends
        fork
            send_frame(8'hC3, 1'b1);
            begin
                repeat (4 * BIT + 20) @(negedge clk);
                #2 rst = 1'b1;
                #1;
                check("async_rst_word", {24'd0, word}, 32'h00);
                check("async_rst_busy", {31'd0, busy}, 32'd0);
                check("async_rst_valid", {31'd0, valid}, 32'd0);
            end
        join
        last_good = 8'h00;
        rst = 1'b0;
        repeat (100) @(negedge clk);
        expect_ev(K_VALID, 8'h81);
        send_frame(8'h81, 1'b1);
        repeat (40) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        expect_ev(K_PARITY, 8'h07);
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        repeat (40) @(negedge clk);
`endif

        // Drain: every expected outcome must have been seen.
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
